// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory controller between the CPU instruction-fetch port
// (f_*) and the load/store port (d_*). One request is captured at a time,
// presented to memctrl for one cycle, then the arbiter waits for memctrl's
// ready and routes it back to the port that won. Ties alternate round-robin.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   f_en/f_cmd/f_ad/f_din   fetch request (held until f_ready)
//   f_ready, f_dout         fetch completion pulse and read data
//   d_en/d_cmd/d_ad/d_din   data request (held until d_ready)
//   d_ready, d_dout         data completion pulse and read data
//   mem_en                  one-cycle request strobe to memctrl
//   mem_cmd/mem_ad/mem_din  latched command, address and write data
//   mem_ready, mem_dout     memctrl completion pulse and read data
//   gnt                     current owner: 00 none, 01 fetch, 10 data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_en,
  input  logic [2:0]    f_cmd,
  input  logic [AW-1:0] f_ad,
  input  logic [DW-1:0] f_din,
  output logic          f_ready,
  output logic [DW-1:0] f_dout,
  input  logic          d_en,
  input  logic [2:0]    d_cmd,
  input  logic [AW-1:0] d_ad,
  input  logic [DW-1:0] d_din,
  output logic          d_ready,
  output logic [DW-1:0] d_dout,
  output logic          mem_en,
  output logic [2:0]    mem_cmd,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          last_data, last_data_next;
  logic [1:0]    gnt_next;
  logic [2:0]    cmd_next;
  logic [AW-1:0] ad_next;
  logic [DW-1:0] din_next;
  logic          pick_data;

  // Read data is broadcast to both ports; only the ready pulses are steered.
  assign f_dout = mem_dout;
  assign d_dout = mem_dout;

  // Data wins when it is the only requester, or on a tie when fetch was the
  // last owner. last_data resets to 0 so data takes the first tie.
  assign pick_data = d_en && (!f_en || !last_data);

  // State register and latched request; the latch only loads in IDLE, so a
  // requester changing its inputs mid-transaction has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      gnt       <= 2'b00;
      mem_cmd   <= '0;
      mem_ad    <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_next;
      last_data <= last_data_next;
      gnt       <= gnt_next;
      mem_cmd   <= cmd_next;
      mem_ad    <= ad_next;
      mem_din   <= din_next;
    end
  end

  // Next-state and output decode. Ready is gated by rst so a memctrl pulse
  // arriving in the reset cycle of an abandoned transaction is not forwarded.
  always_comb begin
    state_next     = state;
    last_data_next = last_data;
    gnt_next       = gnt;
    cmd_next       = mem_cmd;
    ad_next        = mem_ad;
    din_next       = mem_din;
    mem_en         = 1'b0;
    f_ready        = 1'b0;
    d_ready        = 1'b0;

    case (state)
      IDLE: begin
        if (pick_data) begin
          gnt_next   = 2'b10;
          cmd_next   = d_cmd;
          ad_next    = d_ad;
          din_next   = d_din;
          state_next = ISSUE;
        end else if (f_en) begin
          gnt_next   = 2'b01;
          cmd_next   = f_cmd;
          ad_next    = f_ad;
          din_next   = f_din;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          f_ready        = gnt[0] && !rst;
          d_ready        = gnt[1] && !rst;
          last_data_next = gnt[1];
          gnt_next       = 2'b00;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed testbench for mem_arbiter. Inputs are driven 1ns after the rising
// edge and outputs are sampled a further 1ns later, so every check sees the
// registered state of the current cycle plus the combinational ready path.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_en, d_en, mem_ready;
  logic [2:0]    f_cmd, d_cmd;
  logic [AW-1:0] f_ad, d_ad;
  logic [DW-1:0] f_din, d_din, mem_dout;
  logic          f_ready, d_ready, mem_en;
  logic [DW-1:0] f_dout, d_dout, mem_din;
  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_ad;
  logic [1:0]    gnt;

  int checkCount = 0;
  int failCount  = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .f_en(f_en), .f_cmd(f_cmd), .f_ad(f_ad), .f_din(f_din),
    .f_ready(f_ready), .f_dout(f_dout),
    .d_en(d_en), .d_cmd(d_cmd), .d_ad(d_ad), .d_din(d_din),
    .d_ready(d_ready), .d_dout(d_dout),
    .mem_en(mem_en), .mem_cmd(mem_cmd), .mem_ad(mem_ad), .mem_din(mem_din),
    .mem_ready(mem_ready), .mem_dout(mem_dout),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to 1ns after the next rising edge, where new inputs get driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic applyStimulus();
    #1;
  endtask

  initial begin
    rst = 1'b1; f_en = 0; d_en = 0; mem_ready = 0;
    f_cmd = 0; d_cmd = 0; f_ad = 0; d_ad = 0; f_din = 0; d_din = 0; mem_dout = 0;
    tick(); tick();
    rst = 1'b0;
    applyStimulus();

    // Reset state
    checkOutput("rst_mem_en",  mem_en,  0);
    checkOutput("rst_gnt",     gnt,     0);
    checkOutput("rst_f_ready", f_ready, 0);
    checkOutput("rst_d_ready", d_ready, 0);
    checkOutput("rst_mem_ad",  mem_ad,  0);
    checkOutput("rst_mem_cmd", mem_cmd, 0);
    checkOutput("rst_mem_din", mem_din, 0);

    // Single fetch: sampled in cycle 0, mem_en in cycle 1, ready in cycle 3
    $display("[TB] single fetch");
    f_en = 1; f_ad = 32'h100; f_cmd = 3'b010;
    applyStimulus();
    checkOutput("sf_c0_mem_en", mem_en, 0);
    tick();
    checkOutput("sf_c1_mem_en",  mem_en,  1);
    checkOutput("sf_c1_mem_ad",  mem_ad,  32'h100);
    checkOutput("sf_c1_mem_cmd", mem_cmd, 3'b010);
    checkOutput("sf_c1_gnt",     gnt,     2'b01);
    checkOutput("sf_c1_d_ready", d_ready, 0);
    tick();
    checkOutput("sf_c2_mem_en",  mem_en,  0);
    checkOutput("sf_c2_f_ready", f_ready, 0);
    tick();
    mem_ready = 1; mem_dout = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("sf_c3_f_ready", f_ready, 1);
    checkOutput("sf_c3_f_dout",  f_dout,  32'hDEADBEEF);
    checkOutput("sf_c3_d_ready", d_ready, 0);
    checkOutput("sf_c3_d_dout",  d_dout,  32'hDEADBEEF);
    tick();
    mem_ready = 0; f_en = 0;
    applyStimulus();
    checkOutput("sf_c4_gnt",     gnt,     0);
    checkOutput("sf_c4_f_ready", f_ready, 0);

    // Tie after reset: both ports keep requesting; expect D, F, D, F
    $display("[TB] round-robin tie");
    rst = 1; tick(); rst = 0;
    f_en = 1; d_en = 1; f_ad = 32'h1000; d_ad = 32'h2000;
    f_cmd = 3'b010; d_cmd = 3'b001;
    for (int k = 0; k < 4; k++) begin
      logic wantData;
      wantData = (k % 2 == 0);
      tick();
      checkOutput($sformatf("rr%0d_gnt", k), gnt, wantData ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr%0d_ad", k), mem_ad, wantData ? 32'h2000 : 32'h1000);
      checkOutput($sformatf("rr%0d_en", k), mem_en, 1);
      tick();
      mem_ready = 1; mem_dout = 32'hA000 + k;
      applyStimulus();
      checkOutput($sformatf("rr%0d_d_ready", k), d_ready, wantData ? 1 : 0);
      checkOutput($sformatf("rr%0d_f_ready", k), f_ready, wantData ? 0 : 1);
      tick();
      mem_ready = 0;
    end
    f_en = 0; d_en = 0;
    applyStimulus();

    // Store latch: requester inputs change after capture
    $display("[TB] store latch");
    d_en = 1; d_cmd = 3'b110; d_ad = 32'h20; d_din = 32'h55;
    tick();
    d_ad = 32'h99; d_din = 32'hAA;
    applyStimulus();
    checkOutput("st_c1_gnt",     gnt,     2'b10);
    checkOutput("st_c1_mem_cmd", mem_cmd, 3'b110);
    checkOutput("st_c1_mem_ad",  mem_ad,  32'h20);
    checkOutput("st_c1_mem_din", mem_din, 32'h55);
    tick();
    checkOutput("st_c2_mem_ad",  mem_ad,  32'h20);
    checkOutput("st_c2_mem_din", mem_din, 32'h55);
    checkOutput("st_c2_d_ready", d_ready, 0);
    tick();
    checkOutput("st_c3_mem_ad",  mem_ad,  32'h20);
    checkOutput("st_c3_mem_din", mem_din, 32'h55);
    mem_ready = 1; mem_dout = 32'h0;
    applyStimulus();
    checkOutput("st_c3_d_ready", d_ready, 1);
    checkOutput("st_c3_f_ready", f_ready, 0);
    tick();
    mem_ready = 0; d_en = 0;
    applyStimulus();
    checkOutput("st_c4_d_ready", d_ready, 0);
    checkOutput("st_c4_gnt",     gnt,     0);

    // Stray ready in IDLE and in ISSUE is ignored
    $display("[TB] stray ready");
    mem_ready = 1; mem_dout = 32'h12345678;
    applyStimulus();
    checkOutput("sr_idle_f_ready", f_ready, 0);
    checkOutput("sr_idle_d_ready", d_ready, 0);
    tick();
    checkOutput("sr_idle_gnt",    gnt,    0);
    checkOutput("sr_idle_mem_en", mem_en, 0);
    mem_ready = 0; f_en = 1; f_ad = 32'h300; f_cmd = 3'b000;
    tick();
    mem_ready = 1;
    applyStimulus();
    checkOutput("sr_issue_mem_en",  mem_en,  1);
    checkOutput("sr_issue_f_ready", f_ready, 0);
    tick();
    mem_ready = 0;
    applyStimulus();
    checkOutput("sr_wait_gnt",     gnt,     2'b01);
    checkOutput("sr_wait_mem_en",  mem_en,  0);
    checkOutput("sr_wait_f_ready", f_ready, 0);
    tick();
    mem_ready = 1; mem_dout = 32'hCAFE0001;
    applyStimulus();
    checkOutput("sr_done_f_ready", f_ready, 1);
    checkOutput("sr_done_f_dout",  f_dout,  32'hCAFE0001);
    tick();
    mem_ready = 0; f_en = 0;

    // Reset during WAIT abandons the transaction
    $display("[TB] reset mid-wait");
    f_en = 1; f_ad = 32'h400; f_cmd = 3'b010;
    tick();
    tick();
    applyStimulus();
    checkOutput("rw_wait_gnt", gnt, 2'b01);
    rst = 1;
    tick();
    rst = 0; f_en = 0; mem_ready = 1;
    applyStimulus();
    checkOutput("rw_f_ready", f_ready, 0);
    checkOutput("rw_gnt",     gnt,     0);
    checkOutput("rw_mem_en",  mem_en,  0);
    checkOutput("rw_mem_ad",  mem_ad,  0);
    tick();
    mem_ready = 0;
    applyStimulus();
    checkOutput("rw_idle_gnt", gnt, 0);
    f_en = 1; d_en = 1; f_ad = 32'h500; d_ad = 32'h600;
    tick();
    checkOutput("rw_tie_gnt", gnt,    2'b10);
    checkOutput("rw_tie_ad",  mem_ad, 32'h600);
    tick();
    mem_ready = 1;
    applyStimulus();
    checkOutput("rw_tie_d_ready", d_ready, 1);
    checkOutput("rw_tie_f_ready", f_ready, 0);
    tick();
    mem_ready = 0; f_en = 0; d_en = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory controller between the CPU's instruction-fetch path and its load/store path. It captures one request at a time, drives the memory controller's request lines, waits for the controller's ready, and routes ready and read data back to the winning requester. It sits between the CPU sequencing FSM and memctrl. Ties are resolved round-robin, so neither port starves.

## Interface
- AW, 32, address width
- DW, 32, data width

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- f_en  in  1  fetch request; held high until f_ready
- f_cmd  in  3  fetch command: [2]=write, [1:0]=size (0 byte, 1 half, 2 word)
- f_ad  in  AW  fetch address
- f_din  in  DW  fetch write data (unused for reads)
- f_ready  out  1  fetch transaction complete, one-cycle pulse
- f_dout  out  DW  fetch read data, valid while f_ready=1
- d_en, d_cmd, d_ad, d_din, d_ready, d_dout: data port, same directions, widths and meanings as the f_* signals
- mem_en  out  1  request strobe to memctrl, one cycle per transaction
- mem_cmd  out  3  latched command
- mem_ad  out  AW  latched address
- mem_din  out  DW  latched write data
- mem_ready  in  1  memctrl done pulse
- mem_dout  in  DW  memctrl read data, valid with mem_ready
- gnt  out  2  current owner: 00 none, 01 fetch, 10 data

## Operation
- States:
  - IDLE: no transaction in progress.
  - ISSUE: mem_en=1 for exactly one cycle.
  - WAIT: waiting for mem_ready.
- IDLE:
  - Samples f_en and d_en.
  - Only one asserted: that port wins.
  - Both asserted: the port not in last_gnt wins.
  - Winner's cmd, ad and din are latched into mem_cmd, mem_ad and mem_din; gnt is set; next state is ISSUE.
  - Neither asserted: stay in IDLE.
- ISSUE: mem_en=1; next state is WAIT. mem_ready is ignored in ISSUE; memctrl never asserts ready in the same cycle as en.
- WAIT:
  - mem_ready=1: winner's x_ready=1 combinationally in that cycle, x_dout=mem_dout. last_gnt is updated to the winner, gnt clears, next state is IDLE.
  - mem_ready=0: stay in WAIT.
- Loser port: ready is held 0; its request stays pending and is not latched.
- Once latched, the request is immune to changes on the requester's inputs. If the requester drops en mid-transaction, the transaction still completes and the ready pulse is still issued.
- Requester rule: after seeing x_ready, the requester must drop x_en in the following cycle unless it is issuing a new request. A new request in that cycle is a legitimate back-to-back request.
- Non-winner data outputs: f_dout and d_dout equal mem_dout at all times. Only the ready signals are gated.
- The arbiter does not interpret cmd; it passes it through unchanged.

## Timing
- Reset values:
  - state = IDLE, last_gnt = fetch (so data wins the first tie).
  - mem_en, f_ready, d_ready = 0; gnt = 00.
  - mem_cmd, mem_ad, mem_din = 0.
- rst asserted in any state: return to IDLE next cycle. An in-flight memctrl transaction is abandoned and no ready is forwarded. memctrl is reset by the same rst.
- Latency:
  - Request sampled in cycle 0 (IDLE).
  - mem_en high in cycle 1.
  - mem_ready accepted from cycle 2 onward.
  - Minimum request-to-ready latency is 2 cycles.
  - Next arbitration happens in the cycle after ready.
- Throughput: at most one transaction per 3 cycles.
- Round-robin: with both ports continuously requesting, grants alternate D, F, D, F…
- Simultaneous events:
  - A new request arriving during ISSUE or WAIT waits for IDLE.
  - mem_ready outside WAIT is ignored.
  - The winner's en deasserting in the same cycle as mem_ready has no effect.

## Test plan
- Single fetch: f_en=1, f_ad=0x100, f_cmd=010. Expect mem_en pulse in cycle 1 with mem_ad=0x100 and gnt=01. Drive mem_ready=1, mem_dout=0xDEADBEEF in cycle 3. Expect f_ready=1 and f_dout=0xDEADBEEF in cycle 3, d_ready=0 throughout.
- Tie after reset: f_en=d_en=1 held for 4 transactions (each d_en/f_en held until its own ready, then reasserted next cycle). Expect grant order data, fetch, data, fetch. mem_ad alternates between d_ad and f_ad.
- Store latch: d_en=1, d_cmd=110, d_ad=0x20, d_din=0x55. Change d_ad to 0x99 and d_din to 0xAA in cycle 1. Expect mem_ad=0x20 and mem_din=0x55 through WAIT. d_ready pulses once.
- Stray ready: mem_ready=1 during IDLE and during ISSUE. Expect no f_ready/d_ready and no state change. A later mem_ready in WAIT completes normally.
- Reset mid-WAIT: fetch in WAIT, rst=1 for one cycle, then mem_ready=1. Expect IDLE, gnt=00, f_ready=0, mem_en=0. A subsequent tie grants data first.
